// File: rtl/tdc_event_streamer_pkg.sv
// Shared types and helpers for the TDC event streamer.
//   stream_state_t  : streamer FSM state encoding
//   STREAM_HDR_TYPE : 3-bit message type tag placed at the top of each header byte
//   *_MSB / *_W     : field positions inside the 68-bit FIFO event word
//   tdc_event_t     : unpacked view of one event word {chan, ts, width}
//   build_msg_a/b   : frame an event into the two 48-bit USART messages
package tdc_event_streamer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_LATCH,
    ST_SEND_A,
    ST_WAIT_A,
    ST_SEND_B,
    ST_WAIT_B
  } stream_state_t;

  localparam logic [2:0] STREAM_HDR_TYPE = 3'b101;

  localparam int CHAN_MSB  = 67;
  localparam int TS_MSB    = 63;
  localparam int WIDTH_MSB = 31;

  localparam int CHAN_W  = 4;
  localparam int TS_W    = 32;
  localparam int WIDTH_W = 32;
  localparam int SEQ_W   = 4;

  typedef struct packed {
    logic [CHAN_W-1:0]  chan;
    logic [TS_W-1:0]    ts;
    logic [WIDTH_W-1:0] width;
  } tdc_event_t;

  function automatic tdc_event_t unpack_event(input logic [67:0] word);
    tdc_event_t ev;
    ev.chan  = word[CHAN_MSB -: CHAN_W];
    ev.ts    = word[TS_MSB -: TS_W];
    ev.width = word[WIDTH_MSB -: WIDTH_W];
    return ev;
  endfunction

  // Header byte: {type, part, seq}; part 0 = message A, 1 = message B.
  function automatic logic [7:0] build_hdr(input logic part, input logic [SEQ_W-1:0] seq);
    return {STREAM_HDR_TYPE, part, seq};
  endfunction

  function automatic logic [47:0] build_msg_a(input tdc_event_t ev, input logic [SEQ_W-1:0] seq);
    return {build_hdr(1'b0, seq), 4'h0, ev.chan, ev.ts};
  endfunction

  function automatic logic [47:0] build_msg_b(input tdc_event_t ev, input logic [SEQ_W-1:0] seq,
                                              input logic [7:0] pad);
    return {build_hdr(1'b1, seq), pad, ev.width};
  endfunction

endpackage

// File: rtl/tdc_event_streamer_crc8.sv
// CRC-8 over one 68-bit TDC event word (poly 0x07, init 0x00, no reflection,
// no final xor), bits consumed MSB first. Purely combinational.
// Only exists when STREAM_CRC_EN is defined.
//   data_i : event word
//   crc_o  : CRC-8 of data_i
`ifdef STREAM_CRC_EN
module tdc_event_streamer_crc8 #(
  parameter int DATA_W = 68
) (
  input  logic [DATA_W-1:0] data_i,
  output logic [7:0]        crc_o
);

  logic [7:0] crc_v;
  logic       fb_v;

  always_comb begin
    crc_v = 8'h00;
    fb_v  = 1'b0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb_v  = crc_v[7] ^ data_i[i];
      crc_v = {crc_v[6:0], 1'b0} ^ (fb_v ? 8'h07 : 8'h00);
    end
    crc_o = crc_v;
  end

endmodule
`endif

// File: rtl/tdc_event_streamer.sv
// TDC event streamer: pops 68-bit event words from the TDC FIFO and frames each
// into two 48-bit USART messages (A: channel + timestamp, B: pad + width),
// handing them to the USART manager with a send/ack handshake. Counts fully
// sent events (wrapping) and aborted events (saturating).
// Optional feature macro: STREAM_CRC_EN -- pad byte of message B carries a CRC-8
// of the event word instead of 8'h00.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   stream_en      : enables popping new events
//   fifo_empty     : FIFO empty flag
//   fifo_rdata     : FIFO data, valid the cycle after fifo_read
//   fifo_read      : one-cycle pop strobe
//   send_data      : one-cycle send request
//   tx_data        : message, held from send_data until ack/timeout
//   data_sent      : one-cycle ack
//   busy           : FSM not idle
//   event_count    : events with both messages acked
//   timeout_count  : events aborted on ack timeout
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for stream_en and a non-empty FIFO
// POP       | fifo_read strobe
// LATCH     | FIFO data valid; capture event, build message A
// SEND_A    | send_data for message A, arm ack timer
// WAIT_A    | wait for ack of A; on ack load message B
// SEND_B    | send_data for message B, arm ack timer
// WAIT_B    | wait for ack of B; on ack count event, advance seq
module tdc_event_streamer
  import tdc_event_streamer_pkg::*;
#(
  parameter int FIFO_DATA_LENGTH = 68,
  parameter int MSG_LENGTH       = 48,
  parameter int TIMEOUT_CYCLES   = 100000,
  parameter int CNT_WIDTH        = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        stream_en,
  input  logic                        fifo_empty,
  input  logic [FIFO_DATA_LENGTH-1:0] fifo_rdata,
  output logic                        fifo_read,
  output logic                        send_data,
  output logic [MSG_LENGTH-1:0]       tx_data,
  input  logic                        data_sent,
  output logic                        busy,
  output logic [CNT_WIDTH-1:0]        event_count,
  output logic [CNT_WIDTH-1:0]        timeout_count
);

  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Down-counter loaded at send; reaching zero in WAIT is the last cycle an
  // ack is accepted, which lands TIMEOUT_CYCLES cycles after send_data.
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

  stream_state_t         state_q, state_d;
  tdc_event_t            event_q, event_d;
  logic [MSG_LENGTH-1:0] tx_q, tx_d;
  logic [SEQ_W-1:0]      seq_q, seq_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic [CNT_WIDTH-1:0]  ev_cnt_q, ev_cnt_d;
  logic [CNT_WIDTH-1:0]  to_cnt_q, to_cnt_d;

  tdc_event_t rdata_evt;
  logic [7:0] pad_w;
  logic       timer_done;

  assign rdata_evt  = unpack_event(fifo_rdata);
  assign timer_done = (timer_q == '0);

`ifdef STREAM_CRC_EN
  logic [7:0] crc_w;
  logic [7:0] crc_q, crc_d;

  tdc_event_streamer_crc8 #(
    .DATA_W (FIFO_DATA_LENGTH)
  ) u_crc8 (
    .data_i (fifo_rdata),
    .crc_o  (crc_w)
  );

  assign pad_w = crc_q;

  always_comb begin
    crc_d = crc_q;
    if (state_q == ST_LATCH) crc_d = crc_w;
  end

  always_ff @(posedge clk) begin
    if (reset) crc_q <= 8'h00;
    else       crc_q <= crc_d;
  end
`else
  assign pad_w = 8'h00;
`endif

  always_comb begin
    state_d  = state_q;
    event_d  = event_q;
    tx_d     = tx_q;
    seq_d    = seq_q;
    timer_d  = timer_q;
    ev_cnt_d = ev_cnt_q;
    to_cnt_d = to_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (stream_en && !fifo_empty) state_d = ST_POP;
      end
      ST_POP: begin
        state_d = ST_LATCH;
      end
      ST_LATCH: begin
        event_d = rdata_evt;
        tx_d    = build_msg_a(rdata_evt, seq_q);
        state_d = ST_SEND_A;
      end
      ST_SEND_A, ST_SEND_B: begin
        timer_d = TMR_LOAD;
        state_d = (state_q == ST_SEND_A) ? ST_WAIT_A : ST_WAIT_B;
      end
      ST_WAIT_A, ST_WAIT_B: begin
        // An ack in the expiry cycle wins over the timeout.
        if (data_sent) begin
          if (state_q == ST_WAIT_A) begin
            tx_d    = build_msg_b(event_q, seq_q, pad_w);
            state_d = ST_SEND_B;
          end else begin
            ev_cnt_d = ev_cnt_q + CNT_WIDTH'(1);
            seq_d    = seq_q + SEQ_W'(1);
            state_d  = ST_IDLE;
          end
        end else if (timer_done) begin
          if (to_cnt_q != '1) to_cnt_d = to_cnt_q + CNT_WIDTH'(1);
          seq_d   = seq_q + SEQ_W'(1);
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      event_q  <= '0;
      tx_q     <= '0;
      seq_q    <= '0;
      timer_q  <= '0;
      ev_cnt_q <= '0;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      event_q  <= event_d;
      tx_q     <= tx_d;
      seq_q    <= seq_d;
      timer_q  <= timer_d;
      ev_cnt_q <= ev_cnt_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  assign fifo_read     = (state_q == ST_POP);
  assign send_data     = (state_q == ST_SEND_A) || (state_q == ST_SEND_B);
  assign busy          = (state_q != ST_IDLE);
  assign tx_data       = tx_q;
  assign event_count   = ev_cnt_q;
  assign timeout_count = to_cnt_q;

endmodule

// File: tb/tb_tdc_event_streamer.sv
module tb_tdc_event_streamer;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stream_en = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [67:0] fifo_rdata = '0;
  logic        data_sent = 1'b0;
  logic        fifo_read, send_data, busy;
  logic [47:0] tx_data;
  logic [31:0] event_count, timeout_count;

  always #5 clk = ~clk;

  tdc_event_streamer #(
    .FIFO_DATA_LENGTH (68),
    .MSG_LENGTH       (48),
    .TIMEOUT_CYCLES   (T),
    .CNT_WIDTH        (32)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stream_en     (stream_en),
    .fifo_empty    (fifo_empty),
    .fifo_rdata    (fifo_rdata),
    .fifo_read     (fifo_read),
    .send_data     (send_data),
    .tx_data       (tx_data),
    .data_sent     (data_sent),
    .busy          (busy),
    .event_count   (event_count),
    .timeout_count (timeout_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [67:0] act, input logic [67:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [67:0] fifo_q[$];
  int          phase = 0;     // 0 idle, 1 popped, 2 wait A, 3 B due, 4 wait B, 5 back to idle
  int          start_ph = 0;
  int          age = 0;
  int          cnt = 0;
  int          d = 0;
  bit          ack_ok = 1'b0;
  bit          ds = 1'b0;
  bit          exp_busy = 1'b0;
  logic [3:0]  seq_m = '0;
  logic [31:0] ev_m = '0;
  logic [31:0] to_m = '0;
  logic [67:0] cur_evt = '0;
  logic [47:0] cur_msg = '0;
  int          a_delay = 1;   // >0 fixed delay, 0 random, <0 never ack
  int          b_delay = 1;
  bit          stray_en = 1'b0;
  bit          prev_go = 1'b0;
  bit          rst_pending = 1'b0;
  int          pops = 0;
  logic [47:0] last_a = '0;
  logic [47:0] last_b = '0;
  longint      cyc = 0;
  longint      send_b_cyc = 0;
  longint      idle_cyc = 0;

  // CRC-8 as remainder of (word * x^8) mod x^8+x^2+x+1.
  function automatic logic [7:0] crc_ref(input logic [67:0] w);
    logic [75:0] r;
    r = {w, 8'h00};
    for (int i = 75; i >= 8; i--)
      if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
    return r[7:0];
  endfunction

  function automatic logic [47:0] exp_msg_a(input logic [67:0] w, input logic [3:0] s);
    return {3'b101, 1'b0, s, 4'h0, w[67:64], w[63:32]};
  endfunction

  function automatic logic [47:0] exp_msg_b(input logic [67:0] w, input logic [3:0] s);
`ifdef STREAM_CRC_EN
    return {3'b101, 1'b1, s, crc_ref(w), w[31:0]};
`else
    return {3'b101, 1'b1, s, 8'h00, w[31:0]};
`endif
  endfunction

  // Ack delay in cycles after send_data; 0 means never ack.
  function automatic int pick(input int pol);
    if (pol > 0) return pol;
    if (pol < 0) return 0;
    if ($urandom_range(0, 9) == 0) return 0;
    if ($urandom_range(0, 1) == 0) return $urandom_range(1, 3);
    return $urandom_range(1, T);
  endfunction

  // Compare process + FIFO/USART responder, all at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_pending) begin
        chk("rst_busy", busy, 0);
        chk("rst_fifo_read", fifo_read, 0);
        chk("rst_send_data", send_data, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_event_count", event_count, 0);
        chk("rst_timeout_count", timeout_count, 0);
      end
      if (reset) begin
        phase = 0; cnt = 0; seq_m = '0; ev_m = '0; to_m = '0;
        data_sent = 1'b0; prev_go = 1'b0; rst_pending = 1'b1;
        fifo_empty = (fifo_q.size() == 0);
        continue;
      end
      rst_pending = 1'b0;
      start_ph = phase;
      ds = 1'b0;
      exp_busy = (start_ph >= 1 && start_ph <= 4) || (start_ph == 0 && prev_go);
      chk("busy", busy, exp_busy);
      chk("pop_decision", fifo_read, prev_go);
      case (start_ph)
        0, 5: begin
          chk("idle_send", send_data, 0);
          chk("event_count", event_count, ev_m);
          chk("timeout_count", timeout_count, to_m);
          if (start_ph == 5) idle_cyc = cyc;
          phase = 0;
          if (fifo_read) begin
            if (fifo_q.size() == 0) begin
              chk("pop_from_empty", 1, 0);
            end else begin
              cur_evt = fifo_q.pop_front();
              fifo_rdata = cur_evt;
              pops++;
              phase = 1;
              age = 0;
            end
          end
        end
        1: begin
          age++;
          chk("send_a_timing", send_data, (age == 2));
          if (age == 2) begin
            cur_msg = exp_msg_a(cur_evt, seq_m);
            chk("msg_a", tx_data, cur_msg);
            last_a = tx_data;
            d = pick(a_delay);
            ack_ok = (d != 0);
            cnt = ack_ok ? d : T;
            phase = 2;
          end
        end
        2, 4: begin
          chk("wait_send", send_data, 0);
          chk("tx_hold", tx_data, cur_msg);
          cnt--;
          if (cnt == 0) begin
            if (ack_ok) begin
              ds = 1'b1;
              if (start_ph == 2) phase = 3;
              else begin
                ev_m++; seq_m++; phase = 5;
              end
            end else begin
              if (to_m != '1) to_m++;
              seq_m++;
              phase = 5;
            end
          end
        end
        3: begin
          chk("send_b_timing", send_data, 1);
          cur_msg = exp_msg_b(cur_evt, seq_m);
          chk("msg_b", tx_data, cur_msg);
          last_b = tx_data;
          send_b_cyc = cyc;
          d = pick(b_delay);
          ack_ok = (d != 0);
          cnt = ack_ok ? d : T;
          phase = 4;
        end
        default: phase = 0;
      endcase
      // Acks while the DUT is idle or popping/latching must be ignored.
      if (!ds && stray_en && (start_ph == 0 || start_ph == 5 || (start_ph == 1 && phase == 1))
          && $urandom_range(0, 3) == 0)
        ds = 1'b1;
      data_sent = ds;
      fifo_empty = (fifo_q.size() == 0);
      prev_go = (phase == 0) && stream_en && !fifo_empty;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (!(fifo_q.size() == 0 && phase == 0) && n < budget) begin
      tick(1);
      n++;
    end
    if (n >= budget) chk("drain_timeout", 1, 0);
  endtask

  task automatic wait_phase(input int p, input int budget);
    int n;
    n = 0;
    while (phase != p && n < budget) begin
      tick(1);
      n++;
    end
    if (n >= budget) chk("phase_timeout", 1, 0);
  endtask

  function automatic logic [67:0] rnd_evt();
    return {4'($urandom), 32'($urandom), 32'($urandom)};
  endfunction

  initial begin
    logic [67:0] w1;
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [67:0] w1;
    w1 = {4'h1, 32'h0000_1234, 32'h0000_00FF};
    tick(3);
    reset = 1'b0;
    tick(1);
    chk("lit_reset_busy", busy, 0);
    chk("lit_reset_tx", tx_data, 0);
    chk("lit_reset_evcnt", event_count, 0);

    // 1: single event, acks after 3 cycles
    stream_en = 1'b1;
    a_delay = 3; b_delay = 3; pops = 0;
    fifo_q.push_back(w1);
    wait_drain(200);
    chk("t1_msg_a", last_a, 48'hA0_01_0000_1234);
`ifdef STREAM_CRC_EN
    chk("t1_msg_b", last_b, {8'hB0, crc_ref(w1), 32'h0000_00FF});
`else
    chk("t1_msg_b", last_b, 48'hB0_00_0000_00FF);
`endif
    chk("t1_event_count", event_count, 1);
    chk("t1_pops", pops, 1);

    // 2: 17 events with immediate acks, seq wraps
    do_reset();
    a_delay = 1; b_delay = 1; pops = 0;
    for (int i = 0; i < 17; i++) fifo_q.push_back(rnd_evt());
    wait_drain(2000);
    chk("t2_event_count", event_count, 17);
    chk("t2_last_hdr", last_a[47:40], 8'hA0);
    chk("t2_pops", pops, 17);

    // 3: message B never acked, then recovery with next seq
    do_reset();
    a_delay = 1; b_delay = -1;
    fifo_q.push_back(rnd_evt());
    wait_drain(200);
    chk("t3_timeout_count", timeout_count, 1);
    chk("t3_event_count", event_count, 0);
    chk("t3_abort_latency", idle_cyc - send_b_cyc, T + 1);
    b_delay = 1;
    fifo_q.push_back(rnd_evt());
    wait_drain(200);
    chk("t3_next_hdr_a", last_a[47:40], 8'hA1);
    chk("t3_next_hdr_b", last_b[47:40], 8'hB1);
    chk("t3_event_count2", event_count, 1);
    a_delay = -1;
    fifo_q.push_back(rnd_evt());
    wait_drain(200);
    chk("t3_timeout_a", timeout_count, 2);
    a_delay = T; b_delay = T;
    fifo_q.push_back(rnd_evt());
    wait_drain(200);
    chk("t3_ack_at_expiry", event_count, 2);

    // 4: stream_en dropped in WAIT_A
    do_reset();
    a_delay = 5; b_delay = 1; pops = 0;
    for (int i = 0; i < 3; i++) fifo_q.push_back(rnd_evt());
    wait_phase(2, 100);
    stream_en = 1'b0;
    tick(30);
    chk("t4_event_count", event_count, 1);
    chk("t4_pops", pops, 1);
    chk("t4_fifo_left", fifo_q.size(), 2);
    stream_en = 1'b1;
    wait_drain(500);
    chk("t4_event_count2", event_count, 3);

    // 5: reset while waiting for ack of B
    do_reset();
    a_delay = 1; b_delay = -1;
    fifo_q.push_back(rnd_evt());
    fifo_q.push_back(rnd_evt());
    wait_phase(4, 100);
    tick(3);
    reset = 1'b1;
    a_delay = 1; b_delay = 1;
    tick(1);
    reset = 1'b0;
    chk("t5_fifo_not_rewound", fifo_q.size(), 1);
    wait_drain(200);
    chk("t5_event_count", event_count, 1);
    chk("t5_timeout_count", timeout_count, 0);
    chk("t5_hdr", last_a[47:40], 8'hA0);

`ifdef STREAM_CRC_EN
    // 6: CRC pad
    do_reset();
    chk("t6_crc_model_one", crc_ref(68'h1), 8'h07);
    fifo_q.push_back(68'h0);
    wait_drain(200);
    chk("t6_pad_zero", last_b[39:32], 8'h00);
    fifo_q.push_back(68'h1);
    wait_drain(200);
    chk("t6_pad_one", last_b[39:32], 8'h07);
`endif

    // random traffic with stray acks and stream_en toggling
    do_reset();
    a_delay = 0; b_delay = 0; stray_en = 1'b1; pops = 0;
    for (int i = 0; i < 60; i++) begin
      fifo_q.push_back(rnd_evt());
      if ($urandom_range(0, 7) == 0) stream_en = ~stream_en;
      tick($urandom_range(0, 25));
    end
    stream_en = 1'b1;
    wait_drain(20000);
    chk("rnd_all_accounted", event_count + timeout_count, pops);
    stray_en = 1'b0;
    tick(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
